// File: rtl/fiber_evt_pkg.sv
// rtl/fiber_evt_pkg.sv - shared constants and helpers for the fiber event merger
// Purpose: FSM state encoding, default trailer tag, END-word field layout and
//          the trailer-detect helper used by fiber_evt_merger.
// Ports: none (package).
package fiber_evt_pkg;

    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_END  = 2'd2;

    localparam int         TAG_W           = 5;
    localparam logic [4:0] DEF_TRAILER_TAG = 5'b10001;

    // END word layout: tag in the top TAG_W bits, error bit just below it,
    // channel field directly above the word count, count at the bottom.
    localparam int END_ERR_FROM_MSB = TAG_W;
    localparam int END_CH_W         = 4;
    localparam int END_CNT_OFS      = 0;

    function automatic logic is_trailer(input logic [TAG_W-1:0] top_bits,
                                        input logic [TAG_W-1:0] tag);
        return top_bits == tag;
    endfunction

endpackage

// File: rtl/fiber_rr_arbiter.sv
// rtl/fiber_rr_arbiter.sv - combinational round-robin channel picker
// Purpose: returns the first requesting channel searching upward from last+1
//          (wrapping at NCH). The registered choice lives in the parent.
// Ports:
//   req   in  NCH  request vector (channel non-empty)
//   last  in  CW   index of the channel served last
//   grant out CW   winning channel index
//   valid out 1    at least one channel requests
module fiber_rr_arbiter #(
    parameter  int NCH = 4,
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  last,
    output logic [CW-1:0]  grant,
    output logic           valid
);

    always_comb begin
        int             sum;
        logic [CW-1:0]  idx;
        sum   = 0;
        idx   = '0;
        grant = '0;
        valid = 1'b0;
        // Offset 1..NCH so the last-served channel is checked last.
        for (int i = 1; i <= NCH; i++) begin
            sum = int'(last) + i;
            if (sum >= NCH) sum = sum - NCH;
            idx = CW'(sum);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/fiber_evt_merger.sv
// rtl/fiber_evt_merger.sv - merges NCH FWFT event FIFOs into one Aurora event FIFO
// Purpose: round-robin block-level merge. A granted channel is drained through
//          its trailer word, then an END word (tag, error, channel, count) is
//          written. Optional starvation timeout under FIBER_EVT_TIMEOUT_EN.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   ENABLE             transfer enable
//   IN_FIFO_EMPTY      per-channel empty flags (FWFT)
//   EVB_DATA           per-channel head data, channel k at [k*DW +: DW]
//   IN_FIFO_RD         per-channel read strobe (one-hot or zero)
//   OUT_FIFO_FULL      output FIFO full
//   OUT_FIFO_WR        output write strobe
//   EVT_FIFO_DATA      output data
//   EVT_FIFO_END       marks the END word
//   CUR_CH             channel owning the output
//   BLOCK_COUNT        completed blocks (wraps)
//   TIMEOUT_ERR        sticky starvation flag (0 without FIBER_EVT_TIMEOUT_EN)
module fiber_evt_merger
    import fiber_evt_pkg::*;
#(
    parameter  int         NCH         = 4,
    parameter  int         DW          = 32,
    parameter  logic [4:0] TRAILER_TAG = DEF_TRAILER_TAG,
    parameter  int         WC_W        = 16,
    parameter  int         TIMEOUT     = 1024,
    localparam int         CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic [NCH-1:0]    IN_FIFO_EMPTY,
    input  logic [NCH*DW-1:0] EVB_DATA,
    output logic [NCH-1:0]    IN_FIFO_RD,
    input  logic              OUT_FIFO_FULL,
    output logic              OUT_FIFO_WR,
    output logic [DW-1:0]     EVT_FIFO_DATA,
    output logic              EVT_FIFO_END,
    output logic [CW-1:0]     CUR_CH,
    output logic [31:0]       BLOCK_COUNT,
    output logic              TIMEOUT_ERR
);

    logic [1:0]      state;
    logic [CW-1:0]   cur_ch;
    logic [CW-1:0]   last;
    logic [CW-1:0]   grant;
    logic            grant_valid;
    logic [WC_W-1:0] wc;
    logic [31:0]     blk_cnt;
    logic            blk_err;
    logic            to_hit;
    logic [DW-1:0]   head;
    logic [DW-1:0]   end_word;
    logic            xfer_go;
    logic            end_go;
    logic            is_last;

    fiber_rr_arbiter #(.NCH(NCH)) u_arb (
        .req   (~IN_FIFO_EMPTY),
        .last  (last),
        .grant (grant),
        .valid (grant_valid)
    );

    assign head    = EVB_DATA[int'(cur_ch)*DW +: DW];
    assign xfer_go = (state == ST_XFER) & ENABLE & ~OUT_FIFO_FULL & ~IN_FIFO_EMPTY[cur_ch];
    assign end_go  = (state == ST_END) & ENABLE & ~OUT_FIFO_FULL;
    assign is_last = is_trailer(head[DW-1 -: TAG_W], TRAILER_TAG);

    assign IN_FIFO_RD   = xfer_go ? (NCH'(1) << cur_ch) : '0;
    assign OUT_FIFO_WR  = xfer_go | end_go;
    assign EVT_FIFO_END = (state == ST_END);
    assign CUR_CH       = cur_ch;
    assign BLOCK_COUNT  = blk_cnt;

    always_comb begin
        end_word = '0;
        end_word[DW-1 -: TAG_W]                    = TRAILER_TAG;
        end_word[DW-1-END_ERR_FROM_MSB]            = blk_err;
        end_word[END_CNT_OFS+WC_W +: END_CH_W]     = END_CH_W'(cur_ch);
        end_word[END_CNT_OFS +: WC_W]              = wc;
    end

    always_comb begin
        case (state)
            ST_XFER: EVT_FIFO_DATA = head;
            ST_END:  EVT_FIFO_DATA = end_word;
            default: EVT_FIFO_DATA = '0;
        endcase
    end

`ifdef FIBER_EVT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_err;
    logic            starved;

    // Only cycles where a transfer would otherwise happen count as starved.
    assign starved = (state == ST_XFER) & ENABLE & ~OUT_FIFO_FULL & IN_FIFO_EMPTY[cur_ch];
    assign to_hit  = starved & (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt  <= '0;
            to_err  <= 1'b0;
            blk_err <= 1'b0;
        end else begin
            if (state != ST_XFER || xfer_go) to_cnt <= '0;
            else if (starved)                to_cnt <= to_cnt + 1'b1;
            if (to_hit) begin
                blk_err <= 1'b1;
                to_err  <= 1'b1;
            end else if (end_go) begin
                blk_err <= 1'b0;
            end
        end
    end

    assign TIMEOUT_ERR = to_err;
`else
    assign to_hit      = 1'b0;
    assign blk_err     = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_ARB;
            cur_ch  <= '0;
            last    <= CW'(NCH - 1);
            wc      <= '0;
            blk_cnt <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (ENABLE && grant_valid) begin
                        cur_ch <= grant;
                        state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (xfer_go) begin
                        if (wc != '1) wc <= wc + 1'b1;
                        if (is_last) state <= ST_END;
                    end else if (to_hit) begin
                        state <= ST_END;
                    end
                end
                ST_END: begin
                    if (end_go) begin
                        blk_cnt <= blk_cnt + 32'd1;
                        last    <= cur_ch;
                        wc      <= '0;
                        state   <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_fiber_evt_merger.sv
// tb/tb_fiber_evt_merger.sv - directed self-checking bench for fiber_evt_merger
module tb_fiber_evt_merger;

    logic         clk;
    logic         RST;
    logic         ENABLE;
    logic [3:0]   IN_FIFO_EMPTY;
    logic [127:0] EVB_DATA;
    logic [3:0]   IN_FIFO_RD;
    logic         OUT_FIFO_FULL;
    logic         OUT_FIFO_WR;
    logic [31:0]  EVT_FIFO_DATA;
    logic         EVT_FIFO_END;
    logic [1:0]   CUR_CH;
    logic [31:0]  BLOCK_COUNT;
    logic         TIMEOUT_ERR;

    fiber_evt_merger #(
        .NCH(4), .DW(32), .TRAILER_TAG(5'b10001), .WC_W(16), .TIMEOUT(16)
    ) dut (
        .CLK           (clk),
        .RST           (RST),
        .ENABLE        (ENABLE),
        .IN_FIFO_EMPTY (IN_FIFO_EMPTY),
        .EVB_DATA      (EVB_DATA),
        .IN_FIFO_RD    (IN_FIFO_RD),
        .OUT_FIFO_FULL (OUT_FIFO_FULL),
        .OUT_FIFO_WR   (OUT_FIFO_WR),
        .EVT_FIFO_DATA (EVT_FIFO_DATA),
        .EVT_FIFO_END  (EVT_FIFO_END),
        .CUR_CH        (CUR_CH),
        .BLOCK_COUNT   (BLOCK_COUNT),
        .TIMEOUT_ERR   (TIMEOUT_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        full;
        logic [3:0]  rd;
        logic        wr;
        logic        endf;
        logic [31:0] data;
        logic [1:0]  ch;
    } vec_t;

    vec_t        vt[16];
    logic [31:0] mem[4][64];
    int          hd[4];
    int          tl[4];
    logic [31:0] cap_d[64];
    logic        cap_e[64];
    int          cap_t[64];
    logic [32:0] expq[16];
    int          ncap, nends, cyc_n;
    int          n_chk, n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [31:0] w);
        mem[c][tl[c]] = w;
        tl[c]++;
    endtask

    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            if (hd[c] < tl[c]) begin
                IN_FIFO_EMPTY[c]    = 1'b0;
                EVB_DATA[c*32 +: 32] = mem[c][hd[c]];
            end else begin
                IN_FIFO_EMPTY[c]    = 1'b1;
                EVB_DATA[c*32 +: 32] = 32'h0;
            end
        end
    endtask

    // Sample outputs mid-cycle, capture writes, then let the FIFO model pop
    // whatever was read on the clock edge.
    task automatic step();
        logic [3:0] rd;
        #1;
        rd = IN_FIFO_RD;
        if (OUT_FIFO_WR === 1'b1 && ncap < 64) begin
            cap_d[ncap] = EVT_FIFO_DATA;
            cap_e[ncap] = EVT_FIFO_END;
            cap_t[ncap] = cyc_n;
            ncap++;
            if (EVT_FIFO_END === 1'b1) nends++;
        end
        if (OUT_FIFO_FULL || !ENABLE)
            check("stall_quiet", {IN_FIFO_RD, OUT_FIFO_WR}, 64'h0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) if (rd[c] === 1'b1) hd[c]++;
        drive();
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic run_until(input bit on_end, input int n, input int budget, input string name);
        int b;
        b = 0;
        while (((on_end ? nends : ncap) < n) && b < budget) begin
            step();
            b++;
        end
        check(name, 64'((on_end ? nends : ncap) >= n), 64'h1);
    endtask

    task automatic cmp_cap(input string name, input int n);
        check({name, "_count"}, 64'(ncap), 64'(n));
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", name, i), {cap_e[i], cap_d[i]}, expq[i]);
    endtask

    task automatic apply(input int i);
        ENABLE        = vt[i].en;
        OUT_FIFO_FULL = vt[i].full;
        #1;
        check($sformatf("vec%0d", i),
              {IN_FIFO_RD, OUT_FIFO_WR, EVT_FIFO_END, EVT_FIFO_DATA, CUR_CH},
              {vt[i].rd, vt[i].wr, vt[i].endf, vt[i].data, vt[i].ch});
        step();
    endtask

    initial begin
        n_chk = 0; n_fail = 0; ncap = 0; nends = 0; cyc_n = 0;
        for (int c = 0; c < 4; c++) begin hd[c] = 0; tl[c] = 0; end

        // single block on ch0 (rows 0-7), then backpressured block on ch1 (rows 8-15)
        vt[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 2'd0};
        vt[1]  = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 32'h0000_0011, 2'd0};
        vt[2]  = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 32'h0000_0022, 2'd0};
        vt[3]  = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 32'h0000_0033, 2'd0};
        vt[4]  = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 32'h8800_0003, 2'd0};
        vt[5]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 32'h8800_0004, 2'd0};
        vt[6]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 2'd0};
        vt[7]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 2'd0};
        vt[8]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 2'd0};
        vt[9]  = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_00A1, 2'd1};
        vt[10] = '{1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 32'h0000_00A1, 2'd1};
        vt[11] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 32'h8800_00B1, 2'd1};
        vt[12] = '{1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 32'h8800_00B1, 2'd1};
        vt[13] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 32'h8801_0002, 2'd1};
        vt[14] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 32'h8801_0002, 2'd1};
        vt[15] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 2'd1};

        RST = 1'b1; ENABLE = 1'b0; OUT_FIFO_FULL = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_rd",   IN_FIFO_RD, 0);
        check("reset_wr",   OUT_FIFO_WR, 0);
        check("reset_end",  EVT_FIFO_END, 0);
        check("reset_data", EVT_FIFO_DATA, 0);
        check("reset_ch",   CUR_CH, 0);
        check("reset_bc",   BLOCK_COUNT, 0);
        check("reset_to",   TIMEOUT_ERR, 0);

        RST = 1'b0;
        push(0, 32'h11); push(0, 32'h22); push(0, 32'h33); push(0, 32'h8800_0003);
        drive();
        for (int i = 0; i < 8; i++) apply(i);
        check("single_bc", BLOCK_COUNT, 1);
        push(1, 32'hA1); push(1, 32'h8800_00B1);
        drive();
        for (int i = 8; i < 16; i++) apply(i);
        check("bp_bc", BLOCK_COUNT, 2);

        // round robin from last served = 3 (reset value)
        ENABLE = 1'b1; OUT_FIFO_FULL = 1'b0;
        RST = 1'b1; step(); RST = 1'b0;
        check("rr_bc0", BLOCK_COUNT, 0);
        ncap = 0; nends = 0;
        push(0, 32'h100); push(0, 32'h8800_0100);
        push(2, 32'h200); push(2, 32'h8800_0200);
        push(3, 32'h300); push(3, 32'h8800_0300);
        drive();
        run_until(1'b1, 3, 80, "rr_done");
        expq[0] = {1'b0, 32'h100}; expq[1] = {1'b0, 32'h8800_0100}; expq[2] = {1'b1, 32'h8800_0002};
        expq[3] = {1'b0, 32'h200}; expq[4] = {1'b0, 32'h8800_0200}; expq[5] = {1'b1, 32'h8802_0002};
        expq[6] = {1'b0, 32'h300}; expq[7] = {1'b0, 32'h8800_0300}; expq[8] = {1'b1, 32'h8803_0002};
        cmp_cap("rr", 9);
        check("rr_bc", BLOCK_COUNT, 3);

        // ENABLE dropped mid-block for 10 cycles
        ncap = 0; nends = 0;
        push(1, 32'h401); push(1, 32'h402); push(1, 32'h403); push(1, 32'h8800_0404);
        push(2, 32'h501); push(2, 32'h8800_0502);
        drive();
        run_until(1'b0, 2, 20, "drop_start");
        ENABLE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("drop_ch", CUR_CH, 1);
        end
        ENABLE = 1'b1;
        run_until(1'b1, 2, 40, "drop_done");
        expq[0] = {1'b0, 32'h401}; expq[1] = {1'b0, 32'h402}; expq[2] = {1'b0, 32'h403};
        expq[3] = {1'b0, 32'h8800_0404}; expq[4] = {1'b1, 32'h8801_0004};
        expq[5] = {1'b0, 32'h501}; expq[6] = {1'b0, 32'h8800_0502}; expq[7] = {1'b1, 32'h8802_0002};
        cmp_cap("drop", 8);
        check("drop_bc", BLOCK_COUNT, 5);

        // reset mid-block; ch3 would win with a stale pointer, ch0 after reset
        ncap = 0; nends = 0;
        push(2, 32'h601); push(2, 32'h602); push(2, 32'h603); push(2, 32'h8800_0604);
        drive();
        run_until(1'b0, 2, 20, "mid_start");
        RST = 1'b1;
        push(0, 32'h701); push(0, 32'h8800_0702);
        push(3, 32'h801); push(3, 32'h8800_0802);
        drive();
        step();
        #1;
        check("mid_rst_out", {IN_FIFO_RD, OUT_FIFO_WR, EVT_FIFO_END, EVT_FIFO_DATA}, 64'h0);
        check("mid_rst_bc", BLOCK_COUNT, 0);
        check("mid_rst_ch", CUR_CH, 0);
        RST = 1'b0;
        step();
        #1;
        check("mid_grant_ch", CUR_CH, 0);
        check("mid_grant_rd", IN_FIFO_RD, 4'h1);
        nends = 0;
        run_until(1'b1, 3, 80, "mid_drain");
        check("mid_bc", BLOCK_COUNT, 3);

`ifdef FIBER_EVT_TIMEOUT_EN
        RST = 1'b1; step(); RST = 1'b0;
        ncap = 0; nends = 0;
        push(1, 32'h5); push(1, 32'h6);
        drive();
        run_until(1'b1, 1, 60, "to_end");
        check("to_count", ncap, 3);
        check("to_word", {cap_e[2], cap_d[2]}, {1'b1, 32'h8C01_0002});
        check("to_gap", cap_t[2] - cap_t[1], 17);
        check("to_err", TIMEOUT_ERR, 1);
        repeat (3) step();
        check("to_sticky", TIMEOUT_ERR, 1);
        check("to_bc", BLOCK_COUNT, 1);
`else
        check("to_err_zero", TIMEOUT_ERR, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fiber_evt_merger.md
Name: fiber_evt_merger

Overview:
- Parametrised successor of the single-source fiber event handler.
- Merges NCH event-builder output FIFOs (first-word-fall-through) into the single Aurora event FIFO, one complete block at a time.
- Channels are picked round-robin; a block runs through its block trailer word and is closed by an END marker word.
- Adds per-channel arbitration, an END word carrying status, a block counter and a saturating word count.

Parameters:
- NCH, 4, number of input event channels (1..16)
- DW, 32, data width (>=32); the trailer tag is tested on bits [DW-1:DW-5]
- TRAILER_TAG, 5'b10001, value of bits [DW-1:DW-5] that identifies a block trailer
- WC_W, 16, width of the per-block word counter
- TIMEOUT, 1024, mid-block starvation limit in CLK cycles (used only with the optional feature)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- ENABLE  in  1  transfer enable (FIBER_CHANNEL_UP & run enable)
- IN_FIFO_EMPTY  in  NCH  per-channel empty flag, FWFT FIFOs
- EVB_DATA  in  NCH*DW  per-channel head-of-FIFO data; channel k is at [k*DW +: DW]
- IN_FIFO_RD  out  NCH  per-channel read strobe (one-hot or zero)
- OUT_FIFO_FULL  in  1  Aurora event FIFO full
- OUT_FIFO_WR  out  1  Aurora event FIFO write strobe
- EVT_FIFO_DATA  out  DW  data to the Aurora event FIFO
- EVT_FIFO_END  out  1  marks the END word; qualified by OUT_FIFO_WR
- CUR_CH  out  $clog2(NCH) (min 1)  channel currently owning the output
- BLOCK_COUNT  out  32  number of blocks completed; wraps at 2^32
- TIMEOUT_ERR  out  1  sticky starvation flag; held 0 when the feature is absent

Behaviour:
- Reset (RST=1 at a CLK edge):
  - State goes to ARB.
  - CUR_CH=0; the round-robin pointer is set so channel 0 has priority next.
  - BLOCK_COUNT=0, word count=0, TIMEOUT_ERR=0.
  - IN_FIFO_RD=0, OUT_FIFO_WR=0, EVT_FIFO_END=0.
  - Reset mid-block abandons the block; no END word is written.
- States: ARB, XFER, END.
- ARB:
  - If ENABLE=1 and any IN_FIFO_EMPTY bit is 0, register the winner as CUR_CH. The winner is the first non-empty channel searching upward from (last served + 1) mod NCH.
  - Then go to XFER. Arbitration costs 1 cycle.
  - No strobes are asserted in ARB.
- XFER:
  - IN_FIFO_RD[CUR_CH] = OUT_FIFO_WR = ENABLE & ~OUT_FIFO_FULL & ~IN_FIFO_EMPTY[CUR_CH]. Both are combinational.
  - EVT_FIFO_DATA = EVB_DATA[CUR_CH], combinational. Zero latency.
  - Each transfer increments the word count; the count saturates at all-ones.
  - When a transferred word has [DW-1:DW-5]==TRAILER_TAG, go to END. That trailer word itself is transferred.
  - ENABLE=0 or OUT_FIFO_FULL=1 stalls in place; the block is never abandoned.
- END:
  - OUT_FIFO_WR = ENABLE & ~OUT_FIFO_FULL, with EVT_FIFO_END=1. No input read occurs.
  - EVT_FIFO_DATA = {TRAILER_TAG, 1'b0 (error bit), zero padding, CUR_CH in [WC_W+3:WC_W], word count in [WC_W-1:0]}.
  - On the write: BLOCK_COUNT+1, last served <= CUR_CH, word count cleared, go to ARB.
- Outside XFER/END, EVT_FIFO_DATA is 0.
- Back-to-back blocks from the same channel are allowed when no other channel is requesting.
- Minimum overhead per block is 2 cycles (ARB + END).
- NCH=1 degenerates to a single-source handler; ARB still costs 1 cycle.

Optional Feature:
- Macro: FIBER_EVT_TIMEOUT_EN.
- When defined:
  - A counter runs in XFER while IN_FIFO_EMPTY[CUR_CH]=1 and clears on every transfer.
  - When it reaches TIMEOUT, go to END.
  - The END word's error bit [DW-6] is 1; TIMEOUT_ERR is set sticky and cleared only by RST.
  - BLOCK_COUNT still increments.
  - Counting is suspended while ENABLE=0 or OUT_FIFO_FULL=1.
- When not defined: no timeout counter, XFER waits indefinitely, and TIMEOUT_ERR is tied to 0.

Decomposition:
- Package fiber_evt_pkg holds:
  - state encoding (ARB/XFER/END)
  - default TRAILER_TAG
  - END-word field offsets (error bit, channel field, count field)
  - an is_trailer function
- One sub-module, fiber_rr_arbiter (parameter NCH): inputs are the request vector and the last-served index; outputs are the grant index and a valid flag. Purely combinational; the registered choice lives in the parent.

Test Plan:
- Single block: ch0 holds 3 words plus trailer (0x8800_0003), OUT never full → 4 data writes with RD[0], then an END word with channel 0 and count 4; BLOCK_COUNT=1.
- Round-robin: ch0, ch2 and ch3 each hold a 2-word block, last served = 3 → service order is ch0, ch2, ch3, each block followed by its END word; BLOCK_COUNT=3.
- Backpressure: OUT_FIFO_FULL toggles every other cycle, including during END → no RD or WR while full, no lost or duplicated word, END written exactly once.
- ENABLE dropped mid-block for 10 cycles → no strobes during the drop, transfer resumes on the same CUR_CH, and no other channel is granted before END.
- Reset mid-block: RST after the 2nd word → all outputs 0, state ARB, BLOCK_COUNT=0, next grant goes to channel 0.
- With FIBER_EVT_TIMEOUT_EN and TIMEOUT=16: ch1 supplies 2 words and then goes empty → END word after 16 starved cycles with error bit=1, count=2; TIMEOUT_ERR=1 and stays 1.
